// File: rtl/binop_sequencer_pkg.sv
// Shared definitions for the binary-op sequencer: value type codes, trap
// codes, opcode range bounds, FSM state encoding and the decode record.
package binop_sequencer_pkg;

    // Operand-stack value type codes
    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;
    localparam logic [1:0] TYPE_F32 = 2'd2;
    localparam logic [1:0] TYPE_F64 = 2'd3;

    // CPU trap codes
    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
    localparam logic [3:0] TRAP_TYPE      = 4'd2;
    localparam logic [3:0] TRAP_ILLEGAL   = 4'd3;
    localparam logic [3:0] TRAP_DIVZERO   = 4'd4;

    // Opcode ranges: compares first, then arithmetic
    localparam logic [7:0] OP_CMP_LO     = 8'h46;
    localparam logic [7:0] OP_CMP_HI     = 8'h66;
    localparam logic [7:0] OP_I32_CMP_LO = 8'h46;
    localparam logic [7:0] OP_I32_CMP_HI = 8'h4F;
    localparam logic [7:0] OP_I64_CMP_LO = 8'h51;
    localparam logic [7:0] OP_I64_CMP_HI = 8'h5A;
    localparam logic [7:0] OP_F32_CMP_LO = 8'h5B;
    localparam logic [7:0] OP_F32_CMP_HI = 8'h60;
    localparam logic [7:0] OP_F64_CMP_LO = 8'h61;
    localparam logic [7:0] OP_F64_CMP_HI = 8'h66;
    localparam logic [7:0] OP_I32_ARI_LO = 8'h6A;
    localparam logic [7:0] OP_I32_ARI_HI = 8'h78;
    localparam logic [7:0] OP_I64_ARI_LO = 8'h7C;
    localparam logic [7:0] OP_I64_ARI_HI = 8'h8A;
    localparam logic [7:0] OP_F32_ARI_LO = 8'h92;
    localparam logic [7:0] OP_F32_ARI_HI = 8'h98;
    localparam logic [7:0] OP_F64_ARI_LO = 8'hA0;
    localparam logic [7:0] OP_F64_ARI_HI = 8'hA6;
    localparam logic [7:0] OP_I32_DIV_LO = 8'h6D;
    localparam logic [7:0] OP_I32_DIV_HI = 8'h70;
    localparam logic [7:0] OP_I64_DIV_LO = 8'h7F;
    localparam logic [7:0] OP_I64_DIV_HI = 8'h82;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP_B = 3'd1,
        S_POP_A = 3'd2,
        S_EXEC  = 3'd3,
        S_WAIT  = 3'd4,
        S_PUSH  = 3'd5,
        S_TRAP  = 3'd6
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] opnd_type;
        logic [1:0] res_type;
        logic       is_div;
    } decode_t;

    function automatic logic in_range(input logic [7:0] op, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (op >= lo) && (op <= hi);
    endfunction

endpackage

// File: rtl/binop_sequencer_decode.sv
// Combinational opcode classifier: legality, operand type, result type and
// whether the opcode is an integer divide/remainder.
module binop_sequencer_decode
    import binop_sequencer_pkg::*;
(
    input  logic [7:0] opcode_i,
    output decode_t    dec_o
);

    // Classify the opcode by range; compares always produce an i32 flag
    always_comb begin
        dec_o = '0;
        if (in_range(opcode_i, OP_I32_CMP_LO, OP_I32_CMP_HI) ||
            in_range(opcode_i, OP_I32_ARI_LO, OP_I32_ARI_HI)) begin
            dec_o.legal     = 1'b1;
            dec_o.opnd_type = TYPE_I32;
        end else if (in_range(opcode_i, OP_I64_CMP_LO, OP_I64_CMP_HI) ||
                     in_range(opcode_i, OP_I64_ARI_LO, OP_I64_ARI_HI)) begin
            dec_o.legal     = 1'b1;
            dec_o.opnd_type = TYPE_I64;
        end else if (in_range(opcode_i, OP_F32_CMP_LO, OP_F32_CMP_HI) ||
                     in_range(opcode_i, OP_F32_ARI_LO, OP_F32_ARI_HI)) begin
            dec_o.legal     = 1'b1;
            dec_o.opnd_type = TYPE_F32;
        end else if (in_range(opcode_i, OP_F64_CMP_LO, OP_F64_CMP_HI) ||
                     in_range(opcode_i, OP_F64_ARI_LO, OP_F64_ARI_HI)) begin
            dec_o.legal     = 1'b1;
            dec_o.opnd_type = TYPE_F64;
        end
        dec_o.res_type = in_range(opcode_i, OP_CMP_LO, OP_CMP_HI) ? TYPE_I32 : dec_o.opnd_type;
        dec_o.is_div   = in_range(opcode_i, OP_I32_DIV_LO, OP_I32_DIV_HI) ||
                         in_range(opcode_i, OP_I64_DIV_LO, OP_I64_DIV_HI);
    end

endmodule

// File: rtl/binop_sequencer.sv
// Sequences one WebAssembly binary numeric/compare instruction:
// pop b, pop a, type-check, issue ALU, wait for result, push typed result.
// Any fault parks the FSM in TRAP with a sticky code until reset.
// Optional feature macro: BINOP_DIVZERO_TRAP_EN (trap integer div/rem by zero
// in EXEC instead of issuing the ALU).
// Handshake: start is a one-cycle strobe honoured only in IDLE; alu_start is a
// one-cycle issue strobe and alu_done a one-cycle completion strobe that is only
// looked at in WAIT; stack_pop/stack_push act at the clock edge ending the cycle
// in which they are high and are never high together.
module binop_sequencer
    import binop_sequencer_pkg::*;
#(
    parameter int STACK_ADDR = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            opcode,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            trap,
    input  logic [STACK_ADDR:0]   stack_depth,
    input  logic [63:0]           stack_top,
    input  logic [1:0]            stack_top_type,
    output logic                  stack_pop,
    output logic                  stack_push,
    output logic [63:0]           stack_push_data,
    output logic [1:0]            stack_push_type,
    output logic                  alu_start,
    output logic [7:0]            alu_op,
    output logic [63:0]           alu_a,
    output logic [63:0]           alu_b,
    input  logic                  alu_done,
    input  logic [63:0]           alu_result,
    output state_e                dbg_state
);

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] res_q, res_d;
    logic [3:0]  trap_q, trap_d;
    logic [1:0]  opnd_type_q, opnd_type_d;
    logic [1:0]  res_type_q, res_type_d;
    logic        is_div_q, is_div_d;
    decode_t     dec;

    binop_sequencer_decode u_decode (
        .opcode_i (opcode),
        .dec_o    (dec)
    );

    // State and datapath registers; reset wins over every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            trap_q      <= TRAP_NONE;
            opnd_type_q <= TYPE_I32;
            res_type_q  <= TYPE_I32;
            is_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            trap_q      <= trap_d;
            opnd_type_q <= opnd_type_d;
            res_type_q  <= res_type_d;
            is_div_q    <= is_div_d;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        trap_d      = trap_q;
        opnd_type_d = opnd_type_q;
        res_type_d  = res_type_q;
        is_div_d    = is_div_q;
        busy        = 1'b0;
        done        = 1'b0;
        stack_pop   = 1'b0;
        stack_push  = 1'b0;
        alu_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!dec.legal) begin
                        trap_d  = TRAP_ILLEGAL;
                        state_d = S_TRAP;
                    end else if (stack_depth < (STACK_ADDR+1)'(2)) begin
                        trap_d  = TRAP_UNDERFLOW;
                        state_d = S_TRAP;
                    end else begin
                        op_d        = opcode;
                        opnd_type_d = dec.opnd_type;
                        res_type_d  = dec.res_type;
                        is_div_d    = dec.is_div;
                        state_d     = S_POP_B;
                    end
                end
            end
            S_POP_B: begin
                busy      = 1'b1;
                stack_pop = 1'b1;
                b_d       = stack_top;
                if (stack_top_type != opnd_type_q) begin
                    trap_d  = TRAP_TYPE;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_POP_A;
                end
            end
            S_POP_A: begin
                busy      = 1'b1;
                stack_pop = 1'b1;
                a_d       = stack_top;
                if (stack_top_type != opnd_type_q) begin
                    trap_d  = TRAP_TYPE;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
`ifdef BINOP_DIVZERO_TRAP_EN
                // i32 divisors only look at the low word
                if (is_div_q && ((opnd_type_q == TYPE_I32) ? (b_q[31:0] == 32'd0)
                                                           : (b_q == 64'd0))) begin
                    trap_d  = TRAP_DIVZERO;
                    state_d = S_TRAP;
                end else begin
                    alu_start = 1'b1;
                    state_d   = S_WAIT;
                end
`else
                alu_start = 1'b1;
                state_d   = S_WAIT;
`endif
            end
            S_WAIT: begin
                busy = 1'b1;
                if (alu_done) begin
                    // Narrow results are zero-extended into the 64-bit stack slot
                    if ((res_type_q == TYPE_I32) || (res_type_q == TYPE_F32)) begin
                        res_d = {32'd0, alu_result[31:0]};
                    end else begin
                        res_d = alu_result;
                    end
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                busy       = 1'b1;
                stack_push = 1'b1;
                done       = 1'b1;
                state_d    = S_IDLE;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign trap            = trap_q;
    assign alu_op          = op_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign stack_push_data = res_q;
    assign stack_push_type = res_type_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_binop_sequencer.sv
// Bench for binop_sequencer: directed scenarios plus randomized transactions,
// with an operand-stack model, a variable-latency ALU model and a scoreboard.
module tb_binop_sequencer;
  import binop_sequencer_pkg::*;

  localparam logic [1:0] KIND_PUSH = 2'd1;
  localparam logic [1:0] KIND_TRAP = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        busy, done;
  logic [3:0]  trap;
  logic [8:0]  stack_depth = '0;
  logic [63:0] stack_top = '0;
  logic [1:0]  stack_top_type = '0;
  logic        stack_pop, stack_push;
  logic [63:0] stack_push_data;
  logic [1:0]  stack_push_type;
  logic        alu_start;
  logic [7:0]  alu_op;
  logic [63:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [63:0] alu_result = '0;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {kind[1:0], trap[3:0], type[1:0], data[63:0]}
  logic [71:0] exp_q[$];

  // stack / ALU environment state (written only by the main process)
  logic [63:0] sv[0:15];
  logic [1:0]  stt[0:15];
  int sp = 0;
  int pop_cnt = 0, push_cnt = 0, start_cnt = 0, alu_done_cnt = 0;
  int alu_delay = 1, alu_cnt = 0;
  logic [63:0] alu_pend = '0;

  binop_sequencer #(.STACK_ADDR(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .trap(trap),
    .stack_depth(stack_depth), .stack_top(stack_top), .stack_top_type(stack_top_type),
    .stack_pop(stack_pop), .stack_push(stack_push),
    .stack_push_data(stack_push_data), .stack_push_type(stack_push_type),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // ALU behaviour used by the environment model
  function automatic logic [63:0] alu_fn(input logic [7:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    if (op >= 8'h46 && op <= 8'h66) return (a < b) ? 64'd1 : 64'd0;
    if (op == 8'h6A) return a + b;
    if (op == 8'h6B) return a - b;
    return (a * 64'd3) ^ b ^ {56'd0, op};
  endfunction

  // operand type of a legal opcode; returns 0 in legal when not a binop
  function automatic void classify(input logic [7:0] op, output logic legal,
                                   output logic [1:0] ot, output logic [1:0] rt,
                                   output logic is_div);
    int o;
    o = int'(op);
    legal = 1'b1;
    if ((o >= 'h46 && o <= 'h4F) || (o >= 'h6A && o <= 'h78)) ot = TYPE_I32;
    else if ((o >= 'h51 && o <= 'h5A) || (o >= 'h7C && o <= 'h8A)) ot = TYPE_I64;
    else if ((o >= 'h5B && o <= 'h60) || (o >= 'h92 && o <= 'h98)) ot = TYPE_F32;
    else if ((o >= 'h61 && o <= 'h66) || (o >= 'hA0 && o <= 'hA6)) ot = TYPE_F64;
    else begin legal = 1'b0; ot = TYPE_I32; end
    rt = (o >= 'h46 && o <= 'h66) ? TYPE_I32 : ot;
    is_div = (o >= 'h6D && o <= 'h70) || (o >= 'h7F && o <= 'h82);
  endfunction

  // expected outcome of one instruction from stack contents and opcode
  function automatic logic [71:0] expect_of(input logic [7:0] op, input int depth,
                                           input logic [63:0] a, input logic [1:0] ta,
                                           input logic [63:0] b, input logic [1:0] tb);
    logic legal, is_div;
    logic [1:0] ot, rt;
    logic [63:0] r;
    classify(op, legal, ot, rt, is_div);
    if (!legal) return {KIND_TRAP, TRAP_ILLEGAL, 2'd0, 64'd0};
    if (depth < 2) return {KIND_TRAP, TRAP_UNDERFLOW, 2'd0, 64'd0};
    if (tb != ot) return {KIND_TRAP, TRAP_TYPE, 2'd0, 64'd0};
    if (ta != ot) return {KIND_TRAP, TRAP_TYPE, 2'd0, 64'd0};
`ifdef BINOP_DIVZERO_TRAP_EN
    if (is_div && ((ot == TYPE_I32) ? (b[31:0] == 32'd0) : (b == 64'd0)))
      return {KIND_TRAP, TRAP_DIVZERO, 2'd0, 64'd0};
`endif
    r = alu_fn(op, a, b);
    if (rt == TYPE_I32 || rt == TYPE_F32) r = r & 64'h0000_0000_FFFF_FFFF;
    return {KIND_PUSH, TRAP_NONE, rt, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic refresh();
    stack_depth    = 9'(sp);
    stack_top      = (sp > 0) ? sv[sp-1] : 64'd0;
    stack_top_type = (sp > 0) ? stt[sp-1] : 2'd0;
  endtask

  // advance one clock; apply the DUT's stack/ALU strobes of the ending cycle
  task automatic tick();
    logic p, q, s;
    logic [63:0] d, aa, bb;
    logic [1:0] t;
    logic [7:0] o;
    p = stack_pop; q = stack_push; d = stack_push_data; t = stack_push_type;
    s = alu_start; o = alu_op; aa = alu_a; bb = alu_b;
    @(posedge clk);
    #1;
    if (p === 1'b1) begin pop_cnt++; if (sp > 0) sp--; end
    if (q === 1'b1) begin push_cnt++; if (sp < 16) begin sv[sp] = d; stt[sp] = t; sp++; end end
    if (s === 1'b1) begin start_cnt++; alu_cnt = alu_delay; alu_pend = alu_fn(o, aa, bb); end
    alu_done = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin alu_done = 1'b1; alu_result = alu_pend; alu_done_cnt++; end
    end
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // stack holds a below b (b on top); depth 1 keeps only b, depth 0 empty
  task automatic load_stack(input int depth, input logic [63:0] a, input logic [1:0] ta,
                            input logic [63:0] b, input logic [1:0] tb);
    sp = 0;
    if (depth >= 2) begin sv[sp] = a; stt[sp] = ta; sp++; end
    if (depth >= 1) begin sv[sp] = b; stt[sp] = tb; sp++; end
    refresh();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // strobe start for one cycle then wait (bounded) for done or a trap
  task automatic run_op(input logic [7:0] op, output int lat);
    opcode = op;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!(done === 1'b1 || (trap !== 4'd0)) && lat < 60) begin
      tick();
      lat++;
    end
    if (lat >= 60) begin
      checks++;
      errors++;
      $display("FAIL run_op timeout: op %0h no done/trap after %0d cycles", op, lat);
    end
    if (done === 1'b1) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [3:0] prev_trap = 4'd0;
  always @(negedge clk) begin
    logic [71:0] e;
    if (stack_pop === 1'b1 && stack_push === 1'b1) begin
      checks++; errors++;
      $display("FAIL pop_push_overlap: both strobes high");
    end
    if (done !== stack_push && reset === 1'b0) begin
      checks++; errors++;
      $display("FAIL done_vs_push: done %b push %b", done, stack_push);
    end
    if (stack_push === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_push: unexpected push data %0h type %0d", stack_push_data, stack_push_type);
      end else begin
        e = exp_q.pop_front();
        if (e[71:70] != KIND_PUSH || stack_push_data !== e[63:0] || stack_push_type !== e[65:64]) begin
          errors++;
          $display("FAIL sb_push: got data %0h type %0d expected kind %0d data %0h type %0d trap %0d",
                   stack_push_data, stack_push_type, e[71:70], e[63:0], e[65:64], e[69:66]);
        end
      end
    end
    if (trap !== 4'd0 && prev_trap === 4'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_trap: unexpected trap %0d", trap);
      end else begin
        e = exp_q.pop_front();
        if (e[71:70] != KIND_TRAP || trap !== e[69:66]) begin
          errors++;
          $display("FAIL sb_trap: got trap %0d expected kind %0d trap %0d", trap, e[71:70], e[69:66]);
        end
      end
    end
    prev_trap = trap;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int lat;
    logic [71:0] e;
    refresh();
    do_reset();

    // reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trap", 64'(trap), 64'(TRAP_NONE));
    check("rst_pop", 64'(stack_pop), 64'd0);
    check("rst_push", 64'(stack_push), 64'd0);
    check("rst_alu_start", 64'(alu_start), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);

    // i32.sub 3-2 with 1-cycle ALU, latency 5
    alu_delay = 1;
    load_stack(2, 64'd3, TYPE_I32, 64'd2, TYPE_I32);
    exp_q.push_back({KIND_PUSH, TRAP_NONE, TYPE_I32, 64'd1});
    run_op(8'h6B, lat);
    check("sub_latency", 64'(lat), 64'd5);
    check("sub_busy_after", 64'(busy), 64'd0);
    check("sub_stack_top", stack_top, 64'd1);

    // back-to-back: i64.lt_s 5<7 pushes i32 1; operand order checked at issue
    load_stack(2, 64'd5, TYPE_I64, 64'd7, TYPE_I64);
    exp_q.push_back({KIND_PUSH, TRAP_NONE, TYPE_I32, 64'd1});
    opcode = 8'h53;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (alu_start !== 1'b1 && lat < 20) begin tick(); lat++; end
    check("lts_alu_a", alu_a, 64'd5);
    check("lts_alu_b", alu_b, 64'd7);
    check("lts_alu_op", 64'(alu_op), 64'h53);
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    check("lts_done_seen", 64'(done), 64'd1);
    tick();

    // division by zero: trap only when the feature is built in
    load_stack(2, 64'd9, TYPE_I32, 64'd0, TYPE_I32);
    start_cnt = 0;
    e = expect_of(8'h6D, 2, 64'd9, TYPE_I32, 64'd0, TYPE_I32);
    exp_q.push_back(e);
    run_op(8'h6D, lat);
`ifdef BINOP_DIVZERO_TRAP_EN
    check("divz_trap", 64'(trap), 64'(TRAP_DIVZERO));
    check("divz_no_alu", 64'(start_cnt), 64'd0);
    do_reset();
`else
    check("divz_alu_issued", 64'(start_cnt), 64'd1);
    check("divz_trap_none", 64'(trap), 64'(TRAP_NONE));
`endif

    // underflow: no pop, trap next cycle, later starts ignored
    load_stack(1, 64'd0, TYPE_I32, 64'd4, TYPE_I32);
    pop_cnt = 0;
    exp_q.push_back({KIND_TRAP, TRAP_UNDERFLOW, 2'd0, 64'd0});
    opcode = 8'h6A;
    start = 1'b1;
    tick();
    check("uf_trap_next", 64'(trap), 64'(TRAP_UNDERFLOW));
    tick(); tick(); tick();
    start = 1'b0;
    check("uf_no_pop", 64'(pop_cnt), 64'd0);
    check("uf_busy", 64'(busy), 64'd0);
    check("uf_trap_sticky", 64'(trap), 64'(TRAP_UNDERFLOW));
    do_reset();

    // type mismatch on top entry: one pop, no ALU issue
    load_stack(2, 64'd1, TYPE_I32, 64'd2, TYPE_I64);
    pop_cnt = 0;
    start_cnt = 0;
    exp_q.push_back({KIND_TRAP, TRAP_TYPE, 2'd0, 64'd0});
    run_op(8'h6A, lat);
    tick(); tick(); tick();
    check("ty_one_pop", 64'(pop_cnt), 64'd1);
    check("ty_no_alu", 64'(start_cnt), 64'd0);
    check("ty_trap", 64'(trap), 64'(TRAP_TYPE));
    do_reset();

    // reset while waiting on a slow ALU; late alu_done must not push
    alu_delay = 10;
    load_stack(2, 64'd3, TYPE_I32, 64'd2, TYPE_I32);
    push_cnt = 0;
    alu_done_cnt = 0;
    opcode = 8'h6A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("w_in_wait", 64'(dbg_state), 64'(S_WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("w_rst_busy", 64'(busy), 64'd0);
    check("w_rst_alu_a", alu_a, 64'd0);
    check("w_rst_alu_op", 64'(alu_op), 64'd0);
    check("w_rst_trap", 64'(trap), 64'(TRAP_NONE));
    for (int i = 0; i < 14; i++) tick();
    check("w_late_done_seen", 64'(alu_done_cnt), 64'd1);
    check("w_no_push", 64'(push_cnt), 64'd0);
    check("w_idle", 64'(dbg_state), 64'(S_IDLE));

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      int scen, depth;
      logic [7:0] op;
      logic legal, is_div;
      logic [1:0] ot, rt, ta, tb;
      logic [63:0] a, b;
      scen = $urandom_range(0, 9);
      alu_delay = $urandom_range(1, 3);
      do begin
        op = 8'($urandom_range(0, 255));
        classify(op, legal, ot, rt, is_div);
      end while (legal != (scen != 0));
      depth = (scen == 1) ? $urandom_range(0, 1) : 2;
      ta = ot;
      tb = ot;
      if (scen == 2) begin
        if ($urandom_range(0, 1) == 0) tb = 2'(ot + 2'($urandom_range(1, 3)));
        else ta = 2'(ot + 2'($urandom_range(1, 3)));
      end
      a = {32'($urandom), 32'($urandom)};
      b = {32'($urandom), 32'($urandom)};
      if (ot == TYPE_I32 || ot == TYPE_F32) begin a[63:32] = '0; b[63:32] = '0; end
      if (is_div && $urandom_range(0, 2) == 0) b = '0;
      load_stack(depth, a, ta, b, tb);
      e = expect_of(op, depth, a, ta, b, tb);
      exp_q.push_back(e);
      run_op(op, lat);
      if (e[71:70] == KIND_PUSH) begin
        check("rnd_latency", 64'(lat), 64'(4 + alu_delay));
      end else begin
        do_reset();
      end
    end

    for (int i = 0; i < 4; i++) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
